// File: rtl/stream_delay_buffer.sv
// Programmable stream delay line (latency amount+1) with run/done control and a host port.
// Optional build macro STREAM_DELAY_BUFFER_BYPASS_EN: amount==0 passes in0 straight to out0.
module stream_delay_buffer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DELAY_W = 2,
    parameter int unsigned BUF_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  running,
    output logic                  done,
    input  logic [DATA_W-1:0]     in0,
    output logic [DATA_W-1:0]     out0,
    input  logic                  disabled,
    input  logic [BUF_W-1:0]      amount,
    input  logic [DELAY_W-1:0]    delay0,
    output logic [BUF_W-1:0]      fill,
    input  logic                  valid,
    input  logic [1:0]            addr,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic [DATA_W-1:0]     wdata,
    output logic                  rvalid,
    output logic [DATA_W-1:0]     rdata
);

    localparam int unsigned Depth = 2 ** BUF_W;
    localparam logic [BUF_W-1:0] FillMax = '1;
`ifdef STREAM_DELAY_BUFFER_BYPASS_EN
    localparam logic BypassEn = 1'b1;
`else
    localparam logic BypassEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle = 2'd0, StWait = 2'd1, StActive = 2'd2} state_e;

    state_e             state_q, state_d;
    logic [DELAY_W-1:0] dcnt_q, dcnt_d;
    logic [BUF_W-1:0]   wptr_q, wptr_d;
    logic [BUF_W-1:0]   fill_q, fill_d;
    logic [DATA_W-1:0]  out0_q, out0_d;
    logic               armed_q, armed_d;
    logic               rvalid_q;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [DATA_W-1:0]  mem [Depth];
    logic               mem_we;
    logic [DATA_W-1:0]  mem_wdata;

    logic               fill_ok, capture, host_wr, host_rd;
    logic [BUF_W-1:0]   rd_idx;
    logic [DATA_W-1:0]  delayed, out0_reg;

    assign fill_ok = fill_q >= amount;
    assign rd_idx  = wptr_q - amount;
    assign delayed = fill_ok ? ((amount == '0) ? in0 : mem[rd_idx]) : '0;
    // A WAIT cycle with an expired start delay captures just like ACTIVE.
    assign capture = !disabled && !run && running &&
                     (state_q == StActive || (state_q == StWait && dcnt_q == '0));
    assign host_wr = !disabled && !run && valid && (|wstrb) && state_q == StIdle && addr == 2'd0;
    assign host_rd = valid && (wstrb == '0);

    assign done     = disabled || state_q == StIdle ||
                      (state_q == StActive && (armed_q || fill_ok));
    assign out0_reg = disabled ? '0 : out0_q;
`ifdef STREAM_DELAY_BUFFER_BYPASS_EN
    assign out0 = (!disabled && state_q == StActive && running && amount == '0) ? in0 : out0_reg;
`else
    assign out0 = out0_reg;
`endif
    assign fill   = fill_q;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        wptr_d    = wptr_q;
        fill_d    = fill_q;
        out0_d    = out0_q;
        armed_d   = armed_q;
        mem_we    = 1'b0;
        mem_wdata = in0;
        if (disabled) begin
            state_d = StIdle;
            out0_d  = '0;
            armed_d = 1'b0;
        end else if (run) begin
            state_d = StWait;
            dcnt_d  = delay0;
            wptr_d  = '0;
            fill_d  = '0;
            out0_d  = '0;
            armed_d = 1'b0;
        end else begin
            if (state_q == StWait && running && dcnt_q != '0) begin
                dcnt_d = dcnt_q - 1'b1;
                if (dcnt_q == DELAY_W'(1)) state_d = StActive;
            end
            if (state_q == StActive && fill_ok) armed_d = 1'b1;
            if (capture) begin
                state_d = StActive;
                mem_we  = 1'b1;
                wptr_d  = wptr_q + 1'b1;
                fill_d  = (fill_q == FillMax) ? fill_q : fill_q + 1'b1;
                out0_d  = delayed;
            end
            if (host_wr) begin
                mem_we    = 1'b1;
                mem_wdata = wdata;
                wptr_d    = wptr_q + 1'b1;
                fill_d    = (fill_q == FillMax) ? fill_q : fill_q + 1'b1;
            end
        end
    end

    // Reads sample pre-update state.
    always_comb begin
        rdata_d = rdata_q;
        if (host_rd) begin
            rdata_d = '0;
            unique case (addr)
                2'd0: rdata_d = out0_reg;
                2'd1: rdata_d[BUF_W-1:0] = fill_q;
                2'd2: rdata_d[BUF_W-1:0] = wptr_q;
                2'd3: rdata_d[3:0] = {BypassEn, state_q, done};
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            dcnt_q   <= '0;
            wptr_q   <= '0;
            fill_q   <= '0;
            out0_q   <= '0;
            armed_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            wptr_q   <= wptr_d;
            fill_q   <= fill_d;
            out0_q   <= out0_d;
            armed_q  <= armed_d;
            rvalid_q <= host_rd;
            rdata_q  <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wptr_q] <= mem_wdata;
    end

endmodule

// File: tb/tb_stream_delay_buffer.sv
// Directed self-checking bench for stream_delay_buffer (DATA_W=8, DELAY_W=2, BUF_W=4).
module tb_stream_delay_buffer;

    logic       clk = 1'b0;
    logic       rst, run, running, done, disabled, valid, rvalid;
    logic [7:0] in0, out0, wdata, rdata;
    logic [3:0] amount, fill;
    logic [1:0] delay0, addr;
    logic [0:0] wstrb;

    int n_checks = 0;
    int n_errors = 0;

`ifdef STREAM_DELAY_BUFFER_BYPASS_EN
    localparam logic [7:0] BypassBit = 8'h08;
`else
    localparam logic [7:0] BypassBit = 8'h00;
`endif

    stream_delay_buffer #(.DATA_W(8), .DELAY_W(2), .BUF_W(4)) dut (
        .clk(clk), .rst(rst), .run(run), .running(running), .done(done),
        .in0(in0), .out0(out0), .disabled(disabled), .amount(amount), .delay0(delay0),
        .fill(fill), .valid(valid), .addr(addr), .wstrb(wstrb), .wdata(wdata),
        .rvalid(rvalid), .rdata(rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [1:0] a, input logic [7:0] d);
        valid = 1'b1; wstrb = 1'b1; addr = a; wdata = d;
        tick();
        valid = 1'b0; wstrb = 1'b0;
    endtask

    task automatic host_read(input string tag, input logic [1:0] a, input logic [7:0] exp);
        valid = 1'b1; wstrb = 1'b0; addr = a;
        tick();
        valid = 1'b0;
        check_eq({tag, "_rvalid"}, rvalid, 1);
        check_eq(tag, rdata, exp);
        tick();
        check_eq({tag, "_rvalid_pulse"}, rvalid, 0);
    endtask

    task automatic pulse_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    initial begin
        logic [7:0] vals [40];
        rst = 1'b1; run = 0; running = 0; disabled = 0; valid = 0;
        in0 = 0; wdata = 0; amount = 0; delay0 = 0; addr = 0; wstrb = 0;
        tick(); tick();
        rst = 1'b0;
        check_eq("rst_done", done, 1);
        check_eq("rst_out0", out0, 0);
        check_eq("rst_fill", fill, 0);
        check_eq("rst_rvalid", rvalid, 0);
        check_eq("rst_rdata", rdata, 0);

        // Host preload in IDLE; other addresses ignored.
        host_write(2'd0, 8'hA5);
        host_write(2'd1, 8'h33);
        host_read("pre_wptr", 2'd2, 8'd1);
        host_read("pre_fill", 2'd1, 8'd1);

        // Delay path, amount=3.
        amount = 4'd3; delay0 = 2'd0; running = 1'b1;
        pulse_run();
        check_eq("dly_done_wait", done, 0);
        for (int i = 0; i < 12; i++) begin
            in0 = 8'(i + 1);
            tick();
            check_eq($sformatf("dly_out0_%0d", i), out0, (i >= 3) ? i - 2 : 0);
            check_eq($sformatf("dly_done_%0d", i), done, (i >= 2) ? 1 : 0);
        end
        running = 1'b0;
        host_write(2'd0, 8'h5A);
        check_eq("hold_out0", out0, 8'd9);
        host_read("act_wptr", 2'd2, 8'd12);
        host_read("act_fill", 2'd1, 8'd12);
        host_read("act_out0", 2'd0, 8'd9);
        host_read("act_status", 2'd3, 8'h05 | BypassBit);

        // Start delay 3, amount=0.
        amount = 4'd0; delay0 = 2'd3; running = 1'b1;
        pulse_run();
        for (int j = 0; j < 8; j++) begin
            in0 = 8'(8'h10 + j);
            #1;
            check_eq($sformatf("sd_done_%0d", j), done, (j >= 3) ? 1 : 0);
`ifdef STREAM_DELAY_BUFFER_BYPASS_EN
            if (j >= 3) check_eq($sformatf("sd_bypass_%0d", j), out0, in0);
`endif
            tick();
            check_eq($sformatf("sd_out0_%0d", j), out0, (j >= 3) ? 8'h10 + j : 0);
        end

        // Wrap-around, amount=15, latency 16.
        amount = 4'd15; delay0 = 2'd0;
        pulse_run();
        for (int i = 0; i < 40; i++) begin
            vals[i] = 8'((i * 7 + 3) & 8'hFF);
            in0 = vals[i];
            tick();
            check_eq($sformatf("wrap_out0_%0d", i), out0, (i >= 15) ? vals[i - 15] : 8'h00);
        end
        check_eq("wrap_fill_sat", fill, 15);

        // Restart mid-ACTIVE, then reset mid-ACTIVE with a read in flight.
        pulse_run();
        check_eq("restart_fill", fill, 0);
        check_eq("restart_done", done, 0);
        tick(); tick();
        check_eq("reactive_fill", fill, 2);
        rst = 1'b1; valid = 1'b1; wstrb = 1'b0; addr = 2'd0;
        tick();
        check_eq("midrst_out0", out0, 0);
        check_eq("midrst_done", done, 1);
        check_eq("midrst_fill", fill, 0);
        check_eq("midrst_rvalid", rvalid, 0);
        rst = 1'b0; valid = 1'b0;
        host_read("post_rst_status", 2'd3, 8'h01 | BypassBit);

        // Disabled: inert, writes ignored, reads served.
        disabled = 1'b1; amount = 4'd0; delay0 = 2'd0; running = 1'b1;
        pulse_run();
        check_eq("dis_done", done, 1);
        in0 = 8'h66;
        tick(); tick();
        check_eq("dis_out0", out0, 0);
        check_eq("dis_done2", done, 1);
        host_write(2'd0, 8'h77);
        host_read("dis_fill", 2'd1, 8'd0);
        host_read("dis_status", 2'd3, 8'h01 | BypassBit);
        disabled = 1'b0; running = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
